// File: rtl/gsram_pkg.sv
// Shared types for the generic dual-port SRAM controller: FSM states, depth helper,
// and the per-cycle port arbitration result.
package gsram_pkg;

   typedef enum logic {
      ST_CLEAR = 1'b0,
      ST_RUN   = 1'b1
   } gsram_state_e;

   typedef struct packed {
      logic coll;      // both ports write the same word; port 1 loses
      logic we1_keep;  // port 1 write survives arbitration
      logic fwd0;      // port 0 reads the word port 1 is writing
      logic fwd1;      // port 1 reads the word port 0 is writing
   } coll_res_t;

   function automatic int unsigned depth_of(input int unsigned abits);
      return 32'd1 << abits;
   endfunction

   function automatic coll_res_t resolve(input logic ce0, input logic we0,
                                         input logic ce1, input logic we1,
                                         input logic same);
      coll_res_t r;
      logic      w0;
      logic      w1;
      w0         = ce0 & we0;
      w1         = ce1 & we1;
      r.coll     = w0 & w1 & same;
      r.we1_keep = w1 & ~(w0 & same);
      r.fwd0     = ce0 & ~we0 & w1 & same;
      r.fwd1     = ce1 & ~we1 & w0 & same;
      return r;
   endfunction

endpackage

// File: rtl/gsram_dp_array.sv
// Behavioural dual-port word array, no reset; 1-cycle registered read (old data on same-port write).
// Latency: 1 cycle read. Backpressure: none, every port accepts an access each cycle.
module gsram_dp_array
   import gsram_pkg::*;
#(
   parameter int ABITS = 13,
   parameter int DBITS = 2
) (
   input  logic             clk,
   input  logic [ABITS-1:0] a0,
   input  logic [DBITS-1:0] d0,
   input  logic             we0,
   output logic [DBITS-1:0] q0,
   input  logic [ABITS-1:0] a1,
   input  logic [DBITS-1:0] d1,
   input  logic             we1,
   output logic [DBITS-1:0] q1
);

   localparam int unsigned DEPTH = depth_of(ABITS);

   logic [DBITS-1:0] mem [DEPTH];

   // The controller never issues two writes to one word in a cycle.
   always_ff @(posedge clk) begin
      if (we0) mem[a0] <= d0;
      if (we1) mem[a1] <= d1;
      q0 <= mem[a0];
      q1 <= mem[a1];
   end

endmodule

// File: rtl/gsram_dp_ctrl.sv
// Dual-port SRAM controller: post-reset clear, port-0-wins collisions, cross-port forwarding.
// Latency: 1-cycle read, 2 with GSRAM_DP_OUTREG_EN. Backpressure: ports ignored until READY.
module gsram_dp_ctrl
   import gsram_pkg::*;
#(
   parameter int               ABITS    = 13,
   parameter int               DBITS    = 2,
   parameter logic [DBITS-1:0] INIT_VAL = '0
) (
   input  logic             CLK,
   input  logic             RSTN,
   input  logic [ABITS-1:0] A0,
   input  logic [DBITS-1:0] D0,
   input  logic             WE0,
   input  logic             CE0,
   output logic [DBITS-1:0] Q0,
   input  logic [ABITS-1:0] A1,
   input  logic [DBITS-1:0] D1,
   input  logic             WE1,
   input  logic             CE1,
   output logic [DBITS-1:0] Q1,
   output logic             READY,
   output logic             COLL
);

   gsram_state_e     state;
   logic [ABITS-1:0] cnt;
   logic             ready_q;
   logic             coll_q;
   logic             rd0_p, rd1_p, fw0_p, fw1_p;
   logic [DBITS-1:0] fw0_dat, fw1_dat;
   logic [DBITS-1:0] q0_hold, q1_hold, q0_cur, q1_cur;
   logic [DBITS-1:0] aq0, aq1;
   logic [ABITS-1:0] ma0;
   logic [DBITS-1:0] md0;
   logic             mwe0, mwe1;
   coll_res_t        res;

   assign res  = resolve(CE0, WE0, CE1, WE1, A0 == A1);

   // Port 0 of the array is borrowed by the clear sequence.
   assign ma0  = (state == ST_CLEAR) ? cnt : A0;
   assign md0  = (state == ST_CLEAR) ? INIT_VAL : D0;
   assign mwe0 = (state == ST_CLEAR) | (ready_q & CE0 & WE0);
   assign mwe1 = ready_q & res.we1_keep;

   gsram_dp_array #(.ABITS(ABITS), .DBITS(DBITS)) u_array (
      .clk (CLK),
      .a0  (ma0),
      .d0  (md0),
      .we0 (mwe0),
      .q0  (aq0),
      .a1  (A1),
      .d1  (D1),
      .we1 (mwe1),
      .q1  (aq1)
   );

   assign q0_cur = rd0_p ? (fw0_p ? fw0_dat : aq0) : q0_hold;
   assign q1_cur = rd1_p ? (fw1_p ? fw1_dat : aq1) : q1_hold;

   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         state   <= ST_CLEAR;
         cnt     <= '0;
         ready_q <= 1'b0;
         coll_q  <= 1'b0;
         rd0_p   <= 1'b0;
         rd1_p   <= 1'b0;
         fw0_p   <= 1'b0;
         fw1_p   <= 1'b0;
         fw0_dat <= '0;
         fw1_dat <= '0;
         q0_hold <= '0;
         q1_hold <= '0;
      end else begin
         ready_q <= (state == ST_RUN);
         coll_q  <= ready_q & res.coll;
         rd0_p   <= ready_q & CE0 & ~WE0;
         rd1_p   <= ready_q & CE1 & ~WE1;
         fw0_p   <= ready_q & res.fwd0;
         fw1_p   <= ready_q & res.fwd1;
         fw0_dat <= D1;
         fw1_dat <= D0;
         q0_hold <= q0_cur;
         q1_hold <= q1_cur;
         if (state == ST_CLEAR) begin
            cnt <= cnt + 1'b1;
            if (cnt == '1) state <= ST_RUN;
         end
      end
   end

`ifdef GSRAM_DP_OUTREG_EN
   logic [DBITS-1:0] q0_o, q1_o;

   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         q0_o <= '0;
         q1_o <= '0;
      end else begin
         q0_o <= q0_cur;
         q1_o <= q1_cur;
      end
   end

   assign Q0 = q0_o;
   assign Q1 = q1_o;
`else
   assign Q0 = q0_cur;
   assign Q1 = q1_cur;
`endif

   assign READY = ready_q;
   assign COLL  = coll_q;

endmodule

// File: tb/tb_gsram_dp_ctrl.sv
// Bench for gsram_dp_ctrl (ABITS=4, DBITS=8, INIT_VAL=A5): directed cases plus random traffic
// compared every cycle against a word-level memory model.
module tb_gsram_dp_ctrl;

`ifdef GSRAM_DP_OUTREG_EN
   localparam int LAT = 2;
`else
   localparam int LAT = 1;
`endif

   logic       CLK = 1'b0;
   logic       RSTN;
   logic [3:0] A0, A1;
   logic [7:0] D0, D1;
   logic       WE0, CE0, WE1, CE1;
   logic [7:0] Q0, Q1;
   logic       READY, COLL;

   int n_chk = 0;
   int n_err = 0;

   int         edges;
   logic [7:0] ref_mem [16];
   logic [7:0] v0, v1, o0, o1;
   bit         e_coll;

   gsram_dp_ctrl #(.ABITS(4), .DBITS(8), .INIT_VAL(8'hA5)) dut (
      .CLK   (CLK),
      .RSTN  (RSTN),
      .A0    (A0),
      .D0    (D0),
      .WE0   (WE0),
      .CE0   (CE0),
      .Q0    (Q0),
      .A1    (A1),
      .D1    (D1),
      .WE1   (WE1),
      .CE1   (CE1),
      .Q1    (Q1),
      .READY (READY),
      .COLL  (COLL)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      edges  = 0;
      v0     = '0;
      v1     = '0;
      o0     = '0;
      o1     = '0;
      e_coll = 1'b0;
   endtask

   // One rising edge of the memory as seen by a user of the ports.
   task automatic model_edge();
      bit         acc, w0, w1, r0, r1, same;
      logic [7:0] n0, n1;
      acc  = (edges >= 17);
      w0   = acc && CE0 && WE0;
      w1   = acc && CE1 && WE1;
      r0   = acc && CE0 && !WE0;
      r1   = acc && CE1 && !WE1;
      same = (A0 == A1);
      o0   = v0;
      o1   = v1;
      n0   = v0;
      n1   = v1;
      if (r0) n0 = (w1 && same) ? D1 : ref_mem[A0];
      if (r1) n1 = (w0 && same) ? D0 : ref_mem[A1];
      e_coll = w0 && w1 && same;
      if (w1 && !(w0 && same)) ref_mem[A1] = D1;
      if (w0) ref_mem[A0] = D0;
      v0 = n0;
      v1 = n1;
      edges++;
      if (edges == 16)
         for (int i = 0; i < 16; i++) ref_mem[i] = 8'hA5;
   endtask

   task automatic check_outputs();
      chk("q0", Q0, (LAT == 1) ? v0 : o0);
      chk("q1", Q1, (LAT == 1) ? v1 : o1);
      chk("coll", COLL, e_coll);
      chk("ready", READY, edges >= 17);
   endtask

   // Entered and left on a falling edge.
   task automatic cycle(input logic c0, input logic w0, input logic [3:0] a0, input logic [7:0] d0,
                        input logic c1, input logic w1, input logic [3:0] a1, input logic [7:0] d1);
      CE0 = c0; WE0 = w0; A0 = a0; D0 = d0;
      CE1 = c1; WE1 = w1; A1 = a1; D1 = d1;
      @(posedge CLK);
      model_edge();
      @(negedge CLK);
      check_outputs();
   endtask

   task automatic idle();
      cycle(1'b0, 1'b0, 4'd0, 8'h00, 1'b0, 1'b0, 4'd0, 8'h00);
   endtask

   task automatic rnd_cycle();
      logic [3:0] a0, a1;
      a0 = ($urandom_range(0, 1) == 0) ? 4'($urandom_range(0, 3)) : 4'($urandom_range(0, 15));
      a1 = ($urandom_range(0, 1) == 0) ? 4'($urandom_range(0, 3)) : 4'($urandom_range(0, 15));
      cycle(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), a0, 8'($urandom),
            1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), a1, 8'($urandom));
   endtask

   initial begin
      RSTN = 1'b0;
      CE0 = 0; WE0 = 0; A0 = 0; D0 = 0;
      CE1 = 0; WE1 = 0; A1 = 0; D1 = 0;
      for (int i = 0; i < 16; i++) ref_mem[i] = 8'h00;
      model_reset();
      repeat (2) @(negedge CLK);
      chk("rst_q0", Q0, 8'h00);
      chk("rst_q1", Q1, 8'h00);
      chk("rst_ready", READY, 1'b0);
      chk("rst_coll", COLL, 1'b0);

      // Partial clear up to address 9, then reset again.
      RSTN = 1'b1;
      repeat (10) rnd_cycle();
      RSTN = 1'b0;
      #1;
      model_reset();
      chk("midrst_q0", Q0, 8'h00);
      chk("midrst_q1", Q1, 8'h00);
      chk("midrst_ready", READY, 1'b0);
      @(negedge CLK);
      RSTN = 1'b1;

      // Full clear with port activity that must be ignored; READY expected on edge 17.
      repeat (16) begin
         rnd_cycle();
         chk("clr_ready_low", READY, 1'b0);
      end
      rnd_cycle();
      chk("clr_ready_high", READY, 1'b1);

      for (int i = 0; i < 16; i++)
         cycle(1'b1, 1'b0, 4'(i), 8'h00, 1'b1, 1'b0, 4'(15 - i), 8'h00);
      idle();
      chk("clr_last_q0", Q0, 8'hA5);
      chk("clr_last_q1", Q1, 8'hA5);

      // Basic write then read on the other port.
      cycle(1'b1, 1'b0, 4'd1, 8'h00, 1'b0, 1'b0, 4'd0, 8'h00);
      idle();
      cycle(1'b1, 1'b1, 4'd3, 8'h3C, 1'b0, 1'b0, 4'd0, 8'h00);
      chk("rw_q0_hold", Q0, 8'hA5);
      cycle(1'b0, 1'b0, 4'd0, 8'h00, 1'b1, 1'b0, 4'd3, 8'h00);
      idle();
      chk("rw_q1", Q1, 8'h3C);

      // Write-write collision on address 7.
      cycle(1'b1, 1'b1, 4'd7, 8'h11, 1'b1, 1'b1, 4'd7, 8'h22);
      chk("coll_pulse", COLL, 1'b1);
      idle();
      chk("coll_drop", COLL, 1'b0);
      cycle(1'b1, 1'b0, 4'd7, 8'h00, 1'b0, 1'b0, 4'd0, 8'h00);
      idle();
      chk("coll_winner", Q0, 8'h11);

      // Cross-port forwarding in both directions.
      cycle(1'b1, 1'b1, 4'd5, 8'h77, 1'b1, 1'b0, 4'd5, 8'h00);
      idle();
      chk("fwd_q1", Q1, 8'h77);
      cycle(1'b1, 1'b0, 4'd9, 8'h00, 1'b1, 1'b1, 4'd9, 8'h4E);
      idle();
      chk("fwd_q0", Q0, 8'h4E);

      // Different-address double write: no collision.
      cycle(1'b1, 1'b1, 4'd2, 8'hC1, 1'b1, 1'b1, 4'd12, 8'hC2);
      chk("diff_no_coll", COLL, 1'b0);
      cycle(1'b1, 1'b0, 4'd12, 8'h00, 1'b1, 1'b0, 4'd2, 8'h00);
      idle();
      chk("diff_q0", Q0, 8'hC2);
      chk("diff_q1", Q1, 8'hC1);

      repeat (600) rnd_cycle();

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/gsram_dp_ctrl.md
Name: gsram_dp_ctrl

Overview:
Parametrised dual-port synchronous SRAM controller, successor to the fixed-geometry 2-bit GSRAM wrappers. Wraps one behavioural dual-port array and adds:
- a post-reset clear sequence
- deterministic same-address collision resolution
- read-during-write forwarding
- a READY handshake
Used by accelerator private local memories wherever a generic (non-macro) SRAM is synthesised.

Parameters:
ABITS, 13, address width; depth = 2**ABITS words
DBITS, 2, data width per word
INIT_VAL, 0, DBITS-wide value written to every word during the clear sequence

Ports:
CLK  in  1  clock; all state on rising edge
RSTN  in  1  asynchronous active-low reset
A0  in  ABITS  port 0 address
D0  in  DBITS  port 0 write data
WE0  in  1  port 0 write enable (effective only with CE0)
CE0  in  1  port 0 chip enable
Q0  out  DBITS  port 0 read data
A1  in  ABITS  port 1 address
D1  in  DBITS  port 1 write data
WE1  in  1  port 1 write enable
CE1  in  1  port 1 chip enable
Q1  out  DBITS  port 1 read data
READY  out  1  high when clear sequence is done and ports are accepted
COLL  out  1  one-cycle pulse on a dropped write (write-write collision)

Behaviour:
- Reset (RSTN low, asynchronous): Q0=0, Q1=0, READY=0, COLL=0, FSM=CLEAR, clear counter=0. Array contents undefined until CLEAR finishes.
- FSM states: CLEAR, RUN.
  - CLEAR: each cycle writes INIT_VAL at the counter address, then increments the counter. All CE/WE inputs are ignored and Q0/Q1 hold 0.
  - CLEAR -> RUN on the cycle that writes address 2**ABITS-1. That takes exactly 2**ABITS cycles after reset release.
  - READY rises the cycle after the last clear write. RUN is held until the next reset.
- Reset mid-CLEAR or mid-RUN: immediate return to the reset state. The clear restarts from address 0.
- RUN, write: CEx&WEx writes Dx to Ax on the edge. Qx is unchanged on a write cycle.
- RUN, read: CEx&!WEx. Qx = mem[Ax] after the edge (1-cycle latency). Qx holds its last value when CEx=0 or on a write cycle.
- Write-write, same address, both ports writing in the same cycle:
  - port 0 wins; mem = D0
  - port 1 write is dropped
  - COLL=1 for the following cycle only
- Write-write, different addresses: both writes commit, COLL=0.
- Read-during-write, cross port, same address: the reading port returns the newly written data (forwarded). A read that coincides with a dropped port-1 write returns D0.
- Read-read, same or different address: both return mem contents. No hazard.
- Address width is exact. No wrap or out-of-range case exists.

Optional Feature:
Macro GSRAM_DP_OUTREG_EN.
- Defined:
  - an extra output register stage follows Q0/Q1, so read latency is 2 cycles
  - forwarding and collision rules are unchanged, and the forwarded value also appears 2 cycles later
  - COLL timing is unchanged
  - the output register resets to 0
- Undefined: 1-cycle latency as above. No extra flops.

Decomposition:
- Package gsram_pkg:
  - FSM state enum (ST_CLEAR, ST_RUN)
  - localparam helper for depth
  - typedef for the collision-resolve result
- One natural sub-module, gsram_dp_array: pure behavioural dual-port array.
  - ports: clk, a0/a1, d0/d1, we0/we1, q0/q1
  - no reset, 1-cycle read
- The controller owns FSM, clear counter, arbitration muxing, forwarding and output registers.

Test Plan:
- Clear: ABITS=4, DBITS=8, INIT_VAL=8'hA5. Release RSTN. READY=0 for 16 cycles, rises on the 17th edge. Read all 16 addresses -> every Q0 = 8'hA5.
- Basic R/W: write port0 A0=3 D0=8'h3C. Next cycle read port1 A1=3 -> Q1=8'h3C one cycle later. Q0 unchanged during the write.
- Write-write collision: both ports write address 7 with D0=8'h11, D1=8'h22 -> COLL pulses one cycle. A later read of address 7 returns 8'h11.
- Read-during-write forwarding: port0 writes A0=5 D0=8'h77 while port1 reads A1=5 in the same cycle -> Q1=8'h77 next cycle.
- Reset mid-CLEAR: assert RSTN low at clear address 9 -> Q0=Q1=0, READY=0 immediately. After release, READY needs a full 16 cycles again.
- GSRAM_DP_OUTREG_EN defined: rerun the basic R/W case -> Q1=8'h3C appears 2 cycles after the read, not 1.
